formula_1_credit_fifo: RTL and testbench
========================================

// Module: formula_1_credit_fifo
//
// PURPOSE
// - Downstream companion of formula_1_pipe: absorbs its fixed-latency, no-backpressure result stream (res_vld/res).
// - Presents the results to a consumer over a valid/ready interface.
// - Issues arg_rdy credits to the argument source so results in flight never overflow the buffer.
// - Sits between formula_1_pipe outputs and any stallable sink; formula_1_pipe itself stays unmodified.
//
// PARAMETERS
// - WIDTH  32  data width of res / out_data
// - DEPTH  8   FIFO entries, >=2, need not be a power of two
//
// PORTS
// - clk         in   1              system clock, all state on posedge
// - rst         in   1              reset, asynchronous, active-high
// - arg_vld     in   1              an argument set is issued to formula_1_pipe this cycle
// - arg_rdy     out  1              a credit is available; the source may assert arg_vld
// - res_vld     in   1              result valid from formula_1_pipe
// - res         in   WIDTH          result data, sampled only when res_vld=1
// - out_vld     out  1              out_data valid to the consumer
// - out_data    out  WIDTH          head-of-FIFO result
// - out_rdy     in   1              consumer accepts out_data when out_vld & out_rdy
// - count       out  $clog2(DEPTH+1)  entries stored
// - err_ovf     out  1              sticky: a result was dropped (FIFO full, no pop)
// - err_unexp   out  1              sticky: res_vld seen while inflight=0
//
// BEHAVIOUR
// - Reset values: count=0, inflight=0, wr/rd pointers=0, out_vld=0, err_ovf=0, err_unexp=0.
//   - arg_rdy=1 after reset.
//   - out_data is don't-care while out_vld=0.
// - inflight register (0..DEPTH):
//   - +1 on arg_vld & !res_vld; -1 on res_vld & !arg_vld; both or neither -> unchanged.
// - arg_rdy = (count + inflight) < DEPTH, driven combinationally from registers only.
//   - It does not depend on same-cycle arg_vld, res_vld or out_rdy.
// - arg_vld while arg_rdy=0 is a source protocol violation.
//   - inflight still increments, saturating at DEPTH.
// - push = res_vld & !bypass_taken; pop = out_vld & out_rdy.
// - The FIFO is a circular buffer; each pointer wraps from DEPTH-1 to 0.
// - Push and pop in the same cycle:
//   - count is unchanged.
//   - This is legal when full: the pop frees the slot written in that same edge.
// - Push when count=DEPTH and no pop:
//   - Data is dropped; pointers and count are unchanged.
//   - err_ovf <= 1.
// - res_vld when inflight=0:
//   - err_unexp <= 1.
//   - The data is still pushed if space allows; inflight stays 0.
// - out_vld = (count != 0). out_data = mem[rd_ptr].
//   - Latency res_vld -> out_vld is 1 cycle into an empty FIFO.
// - Sticky errors clear only on rst.
// - Reset asserted mid-operation:
//   - All state and errors clear immediately (asynchronous).
//   - In-flight results that arrive after reset deassertion set err_unexp.
// - Arithmetic: count + inflight is evaluated at $clog2(2*DEPTH+1) bits, so there is no wrap.
//
// CONFIGURATION
// - Macro FORMULA_1_CREDIT_FIFO_BYPASS_EN.
// - Defined:
//   - When count=0 and res_vld=1: out_vld=1 and out_data=res in the same cycle (0-cycle latency).
//   - If out_rdy=1 in that cycle, bypass_taken=1: no push, and count stays 0.
//   - Otherwise the result is pushed normally.
// - Undefined: bypass_taken=0 always; out_vld is purely registered.
//
// TESTING
// - Reset, then one arg_vld, then res_vld with res=32'h0000_0005 two cycles later, out_rdy=1.
//   - Expect out_vld one cycle after res_vld with out_data=5, count back to 0, arg_rdy=1 throughout.
// - DEPTH=8: assert arg_vld every cycle while arg_rdy=1, out_rdy=0.
//   - Expect exactly 8 issues, then arg_rdy=0.
//   - Returning 8 results gives count=8; err_ovf=0.
// - Full FIFO with out_rdy=1 and res_vld=1 in the same cycle (a source protocol violation):
//   - count stays 8, the head pops, the new data is stored at the tail, and the pointers wrap.
//   - err_ovf stays 0.
// - Force res_vld=1 with inflight=0: err_unexp=1.
//   - Force a push into a full FIFO with out_rdy=0: err_ovf=1, the data is absent from the output sequence, and the flag persists until rst.
// - Random arg_vld and out_rdy (50%) with a 6-cycle return for 1000 results:
//   - Output order is identical to issue order.
//   - No error flags.
//   - count+inflight never exceeds DEPTH.
// - With FORMULA_1_CREDIT_FIFO_BYPASS_EN, FIFO empty, res_vld=1, res=7, out_rdy=1:
//   - out_vld=1 and out_data=7 in the same cycle; count stays 0.
//   - With the macro undefined, the same stimulus gives out_vld one cycle later.

Source files
------------

// File: rtl/formula_1_credit_fifo.sv
`default_nettype none
// ============================================================================
// Module   : formula_1_credit_fifo
// Brief    : Credit-managed result FIFO placed behind formula_1_pipe. Optional
//            0-cycle empty bypass via FORMULA_1_CREDIT_FIFO_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module formula_1_credit_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       arg_vld,
  output logic                       arg_rdy,
  input  logic                       res_vld,
  input  logic [WIDTH-1:0]           res,
  output logic                       out_vld,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_rdy,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       err_ovf,
  output logic                       err_unexp
);

  localparam int c_cw = $clog2(DEPTH + 1);
  localparam int c_pw = $clog2(DEPTH);
  localparam int c_sw = $clog2(2 * DEPTH + 1);

  localparam logic [c_cw-1:0] c_depth   = c_cw'(DEPTH);
  localparam logic [c_cw-1:0] c_one     = c_cw'(1);
  localparam logic [c_pw-1:0] c_last    = c_pw'(DEPTH - 1);
  localparam logic [c_pw-1:0] c_ptr_one = c_pw'(1);
  localparam logic [c_sw-1:0] c_depth_s = c_sw'(DEPTH);

  logic [c_cw-1:0]  count_q, count_d;
  logic [c_cw-1:0]  inflight_q, inflight_d;
  logic [c_pw-1:0]  wr_ptr_q, wr_ptr_d;
  logic [c_pw-1:0]  rd_ptr_q, rd_ptr_d;
  logic             err_ovf_q, err_ovf_d;
  logic             err_unexp_q, err_unexp_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic             w_empty;
  logic             w_full;
  logic             w_bypass_taken;
  logic             w_push;
  logic             w_fifo_pop;
  logic             w_wr_en;
  logic [c_sw-1:0]  w_occupancy;

  function automatic logic [c_pw-1:0] f_next_ptr(input logic [c_pw-1:0] p);
    return (p == c_last) ? '0 : p + c_ptr_one;
  endfunction

  // Credit check widened so stored + in-flight can never wrap.
  assign w_occupancy = c_sw'(count_q) + c_sw'(inflight_q);
  assign arg_rdy     = w_occupancy < c_depth_s;

  assign w_empty = (count_q == '0);
  assign w_full  = (count_q == c_depth);

`ifdef FORMULA_1_CREDIT_FIFO_BYPASS_EN
  assign w_bypass_taken = w_empty & res_vld & out_rdy;
  assign out_vld        = ~w_empty | res_vld;
  assign out_data       = w_empty ? res : mem_q[rd_ptr_q];
`else
  assign w_bypass_taken = 1'b0;
  assign out_vld        = ~w_empty;
  assign out_data       = mem_q[rd_ptr_q];
`endif

  // Only stored entries pop; a bypassed result never touches the buffer.
  assign w_fifo_pop = ~w_empty & out_rdy;
  assign w_push     = res_vld & ~w_bypass_taken;
  assign w_wr_en    = w_push & (~w_full | w_fifo_pop);

  always_comb begin
    count_d     = count_q;
    inflight_d  = inflight_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    err_ovf_d   = err_ovf_q;
    err_unexp_d = err_unexp_q;
    mem_d       = mem_q;

    if (w_wr_en) begin
      mem_d[wr_ptr_q] = res;
      wr_ptr_d        = f_next_ptr(wr_ptr_q);
    end
    if (w_fifo_pop) begin
      rd_ptr_d = f_next_ptr(rd_ptr_q);
    end

    if (w_wr_en & ~w_fifo_pop) begin
      count_d = count_q + c_one;
    end else if (~w_wr_en & w_fifo_pop) begin
      count_d = count_q - c_one;
    end

    if (arg_vld & ~res_vld) begin
      if (inflight_q != c_depth) begin
        inflight_d = inflight_q + c_one;
      end
    end else if (res_vld & ~arg_vld) begin
      if (inflight_q != '0) begin
        inflight_d = inflight_q - c_one;
      end
    end

    if (w_push & w_full & ~w_fifo_pop) begin
      err_ovf_d = 1'b1;
    end
    if (res_vld & (inflight_q == '0)) begin
      err_unexp_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      inflight_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      err_ovf_q   <= 1'b0;
      err_unexp_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      inflight_q  <= inflight_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      err_ovf_q   <= err_ovf_d;
      err_unexp_q <= err_unexp_d;
    end
  end

  // Storage carries no reset; contents are only observed while count != 0.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign count     = count_q;
  assign err_ovf   = err_ovf_q;
  assign err_unexp = err_unexp_q;

endmodule
`default_nettype wire

// File: tb/tb_formula_1_credit_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_formula_1_credit_fifo
// Brief    : Directed and randomised self-checking bench for the credit FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module tb_formula_1_credit_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int N_RND = 1000;
  localparam int LAT   = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             arg_vld;
  logic             arg_rdy;
  logic             res_vld;
  logic [WIDTH-1:0] res;
  logic             out_vld;
  logic [WIDTH-1:0] out_data;
  logic             out_rdy;
  logic [3:0]       count;
  logic             err_ovf;
  logic             err_unexp;

  int vecs = 0;
  int errs = 0;

  formula_1_credit_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .arg_vld   (arg_vld),
    .arg_rdy   (arg_rdy),
    .res_vld   (res_vld),
    .res       (res),
    .out_vld   (out_vld),
    .out_data  (out_data),
    .out_rdy   (out_rdy),
    .count     (count),
    .err_ovf   (err_ovf),
    .err_unexp (err_unexp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle well before the next one.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int issued;
    int iss;
    int rcv;
    int cyc;
    int npop;
    int maxocc;
    logic [31:0] exp_seq [8];
    logic        dl_v [LAT];
    logic [31:0] dl_d [LAT];
    logic [31:0] expq [$];

    rst = 1'b1; arg_vld = 1'b0; res_vld = 1'b0; res = '0; out_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_arg_rdy", arg_rdy, 1);
    chk("rst_err_ovf", err_ovf, 0);
    chk("rst_err_unexp", err_unexp, 0);

    // single transaction, result two cycles after issue
    arg_vld = 1'b1; tick(); arg_vld = 1'b0;
    chk("t1_arg_rdy_a", arg_rdy, 1);
    tick();
    res_vld = 1'b1; res = 32'h0000_0005; tick(); res_vld = 1'b0;
    chk("t1_out_vld", out_vld, 1);
    chk("t1_out_data", out_data, 32'h5);
    chk("t1_count1", count, 1);
    chk("t1_arg_rdy_b", arg_rdy, 1);
    out_rdy = 1'b1; tick(); out_rdy = 1'b0;
    chk("t1_count0", count, 0);
    chk("t1_out_vld0", out_vld, 0);
    chk("t1_arg_rdy_c", arg_rdy, 1);

    // exhaust credits with the consumer stalled
    issued = 0;
    for (int i = 0; i < 12; i++) begin
      arg_vld = arg_rdy;
      if (arg_rdy) issued++;
      tick();
    end
    arg_vld = 1'b0;
    chk("t2_issued", issued, 8);
    chk("t2_arg_rdy", arg_rdy, 0);
    for (int i = 0; i < 8; i++) begin
      res_vld = 1'b1; res = 32'd100 + i; tick();
    end
    res_vld = 1'b0;
    chk("t2_count", count, 8);
    chk("t2_arg_rdy_full", arg_rdy, 0);
    chk("t2_err_ovf", err_ovf, 0);
    chk("t2_err_unexp", err_unexp, 0);
    chk("t2_head", out_data, 32'd100);

    // push and pop on a full FIFO in the same edge
    arg_vld = 1'b1; tick(); arg_vld = 1'b0;
    res_vld = 1'b1; res = 32'd200; out_rdy = 1'b1;
    #1 chk("t3_head_before", out_data, 32'd100);
    tick(); res_vld = 1'b0; out_rdy = 1'b0;
    chk("t3_count", count, 8);
    chk("t3_head_after", out_data, 32'd101);
    chk("t3_err_ovf", err_ovf, 0);
    chk("t3_err_unexp", err_unexp, 0);
    for (int i = 0; i < 7; i++) exp_seq[i] = 32'd101 + i;
    exp_seq[7] = 32'd200;
    out_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t3_drain", out_data, exp_seq[i]);
      tick();
    end
    out_rdy = 1'b0;
    chk("t3_count0", count, 0);
    chk("t3_out_vld0", out_vld, 0);

    // unexpected result, then overflow
    res_vld = 1'b1; res = 32'd9; tick(); res_vld = 1'b0;
    chk("t4_err_unexp", err_unexp, 1);
    chk("t4_err_ovf0", err_ovf, 0);
    chk("t4_count", count, 1);
    chk("t4_data", out_data, 32'd9);
    out_rdy = 1'b1; tick(); out_rdy = 1'b0;
    chk("t4_count0", count, 0);
    for (int i = 0; i < 8; i++) begin
      res_vld = 1'b1; res = 32'd300 + i; tick();
    end
    res = 32'd999; tick(); res_vld = 1'b0;
    chk("t5_count", count, 8);
    chk("t5_err_ovf", err_ovf, 1);
    out_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t5_drain", out_data, 32'd300 + i);
      tick();
    end
    out_rdy = 1'b0;
    chk("t5_count0", count, 0);
    chk("t5_out_vld0", out_vld, 0);
    chk("t5_err_ovf_sticky", err_ovf, 1);

    // asynchronous reset clears flags before any edge
    rst = 1'b1;
    #1;
    chk("t6_async_ovf", err_ovf, 0);
    chk("t6_async_unexp", err_unexp, 0);
    tick(); rst = 1'b0;
    #1 chk("t6_arg_rdy", arg_rdy, 1);

    // result in flight across a reset is unexpected afterwards
    tick();
    arg_vld = 1'b1; tick(); arg_vld = 1'b0;
    rst = 1'b1; #1 rst = 1'b0;
    res_vld = 1'b1; res = 32'd0; tick(); res_vld = 1'b0;
    chk("t7_unexp_after_rst", err_unexp, 1);
    rst = 1'b1; #1 rst = 1'b0;
    chk("t7_cleared", err_unexp, 0);

    // empty-FIFO result with a ready consumer
    arg_vld = 1'b1; tick(); arg_vld = 1'b0;
    res_vld = 1'b1; res = 32'd7; out_rdy = 1'b1;
    #1;
`ifdef FORMULA_1_CREDIT_FIFO_BYPASS_EN
    chk("t8_byp_vld", out_vld, 1);
    chk("t8_byp_data", out_data, 32'd7);
    tick(); res_vld = 1'b0;
    chk("t8_byp_count", count, 0);
    chk("t8_byp_vld_after", out_vld, 0);
`else
    chk("t8_nobyp_vld", out_vld, 0);
    tick(); res_vld = 1'b0;
    chk("t8_vld", out_vld, 1);
    chk("t8_data", out_data, 32'd7);
    chk("t8_count1", count, 1);
    tick();
    chk("t8_count0", count, 0);
`endif
    out_rdy = 1'b0;
    chk("t8_err_unexp", err_unexp, 0);
    tick();

    // random traffic through a fixed-latency return model
    for (int i = 0; i < LAT; i++) begin
      dl_v[i] = 1'b0;
      dl_d[i] = '0;
    end
    iss = 0; rcv = 0; cyc = 0; maxocc = 0;
    while (rcv < N_RND && cyc < 20000) begin
      arg_vld = (iss < N_RND) && arg_rdy && ($urandom_range(0, 1) == 1);
      out_rdy = ($urandom_range(0, 1) == 1);
      res_vld = dl_v[LAT-1];
      res     = dl_d[LAT-1];
      #1;
      if (out_vld && out_rdy) begin
        if (expq.size() == 0) begin
          chk("rnd_extra_pop", 1, 0);
        end else begin
          chk("rnd_order", out_data, expq.pop_front());
          rcv++;
        end
      end
      tick();
      for (int i = LAT - 1; i > 0; i--) begin
        dl_v[i] = dl_v[i-1];
        dl_d[i] = dl_d[i-1];
      end
      dl_v[0] = arg_vld;
      dl_d[0] = 32'h1000 + iss;
      if (arg_vld) begin
        expq.push_back(32'h1000 + iss);
        iss++;
      end
      npop = 0;
      for (int i = 0; i < LAT; i++) if (dl_v[i]) npop++;
      if (expq.size() > maxocc) maxocc = expq.size();
      chk("rnd_count", count, 32'(expq.size() - npop));
      chk("rnd_arg_rdy", arg_rdy, (expq.size() < DEPTH) ? 1 : 0);
      cyc++;
    end
    arg_vld = 1'b0; res_vld = 1'b0; out_rdy = 1'b0;
    chk("rnd_received", rcv, N_RND);
    chk("rnd_max_occ_ok", (maxocc <= DEPTH) ? 1 : 0, 1);
    chk("rnd_err_ovf", err_ovf, 0);
    chk("rnd_err_unexp", err_unexp, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
